// File: rtl/ps2_pkg.sv
// ps2_pkg: shared state encoding, command constants and frame helper for the PS/2 host path
package ps2_pkg;

    typedef enum logic [3:0] {
        IDLE,
        INHIBIT,
        RTS,
        WAIT_FIRST,
        SEND,
        ACK,
        WAIT_IDLE,
        DONE,
        ERR
    } state_t;

    localparam int TIMER_W = 21;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] RESP_ACK     = 8'hFA;

    // Shift-out order is d0..d7 then odd parity, LSB first.
    function automatic logic [8:0] frame_of(input logic [7:0] d);
        return {~^d, d};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: 2-FF synchronizer, stability filter and falling-edge detect for one PS/2 line
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic line_in,
    output logic filt,
    output logic fall
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= 2'b11;
            cnt  <= '0;
            filt <= 1'b1;
            prev <= 1'b1;
        end else begin
            sync <= {sync[0], line_in};
            prev <= filt;
            if (sync[1] == filt)
                cnt <= '0;
            else if (cnt == CW'(FILTER_LEN - 1)) begin
                filt <= sync[1];
                cnt  <= '0;
            end else
                cnt <= cnt + CW'(1);
        end
    end

    assign fall = prev & ~filt;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter (inhibit, request-to-send, 11 clocks + ACK)
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES     = 12000,
    parameter int RTS_CYCLES         = 200,
    parameter int FIRST_EDGE_TIMEOUT = 1500000,
    parameter int PACKET_TIMEOUT     = 200000,
    parameter int FILTER_LEN         = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err
);

    state_t               state, state_d;
    logic [TIMER_W-1:0]   timer, timer_d, timer_inc;
    logic [8:0]           shift, shift_d;
    logic [3:0]           bitcnt, bitcnt_d;
    logic                 clk_oe_d, data_oe_d, busy_d;
    logic                 clk_f, clk_fall, data_f, data_fall_unused;
    logic                 pkt_to;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk     (clk),
        .rst     (rst),
        .line_in (ps2_clk_in),
        .filt    (clk_f),
        .fall    (clk_fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
        .clk     (clk),
        .rst     (rst),
        .line_in (ps2_data_in),
        .filt    (data_f),
        .fall    (data_fall_unused)
    );

    assign timer_inc = (timer == '1) ? timer : timer + TIMER_W'(1);
    assign pkt_to    = timer >= TIMER_W'(PACKET_TIMEOUT);
    assign tx_done   = state == DONE;
    assign tx_err    = state == ERR;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            timer       <= '0;
            shift       <= '0;
            bitcnt      <= '0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_busy     <= 1'b0;
        end else begin
            state       <= state_d;
            timer       <= timer_d;
            shift       <= shift_d;
            bitcnt      <= bitcnt_d;
            ps2_clk_oe  <= clk_oe_d;
            ps2_data_oe <= data_oe_d;
            tx_busy     <= busy_d;
        end
    end

    // The packet timer is cleared only on entry to SEND, so it spans SEND, ACK and WAIT_IDLE.
    always_comb begin
        state_d   = state;
        timer_d   = timer_inc;
        shift_d   = shift;
        bitcnt_d  = bitcnt;
        clk_oe_d  = ps2_clk_oe;
        data_oe_d = ps2_data_oe;
        busy_d    = tx_busy;
        case (state)
            IDLE: begin
                timer_d = '0;
                if (tx_start) begin
                    shift_d  = frame_of(tx_data);
                    busy_d   = 1'b1;
                    clk_oe_d = 1'b1;
                    state_d  = INHIBIT;
                end
            end
            INHIBIT: if (timer == TIMER_W'(INHIBIT_CYCLES - 1)) begin
                data_oe_d = 1'b1;
                timer_d   = '0;
                state_d   = RTS;
            end
            RTS: if (timer == TIMER_W'(RTS_CYCLES - 1)) begin
                clk_oe_d = 1'b0;
                timer_d  = '0;
                bitcnt_d = '0;
                state_d  = WAIT_FIRST;
            end
            WAIT_FIRST: begin
                if (clk_fall) begin
                    data_oe_d = ~shift[0];
                    shift_d   = shift >> 1;
                    bitcnt_d  = 4'd1;
                    timer_d   = '0;
                    state_d   = SEND;
                end else if (timer >= TIMER_W'(FIRST_EDGE_TIMEOUT))
                    state_d = ERR;
            end
            SEND: begin
                if (pkt_to)
                    state_d = ERR;
                else if (clk_fall && bitcnt == 4'd9) begin
                    data_oe_d = 1'b0;
                    state_d   = ACK;
                end else if (clk_fall) begin
                    data_oe_d = ~shift[0];
                    shift_d   = shift >> 1;
                    bitcnt_d  = bitcnt + 4'd1;
                end
            end
            ACK: begin
                if (pkt_to)
                    state_d = ERR;
                else if (clk_fall)
                    state_d = data_f ? ERR : WAIT_IDLE;
            end
            WAIT_IDLE: begin
                if (pkt_to)
                    state_d = ERR;
                else if (clk_f && data_f)
                    state_d = DONE;
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            ERR: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (state_d == ERR) begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed table-driven bench with a cycle-scaled PS/2 device model
module tb_ps2_host_tx;

    localparam int INH  = 40;
    localparam int RTSC = 10;
    localparam int FET  = 1000;
    localparam int PKT  = 3000;
    localparam int FLT  = 4;
    localparam int HALF = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_err;
    logic       clk_line, data_line;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int err_cnt = 0;

    assign clk_line  = ~ps2_clk_oe & dev_clk;
    assign data_line = ~ps2_data_oe & dev_data;

    ps2_host_tx #(
        .INHIBIT_CYCLES     (INH),
        .RTS_CYCLES         (RTSC),
        .FIRST_EDGE_TIMEOUT (FET),
        .PACKET_TIMEOUT     (PKT),
        .FILTER_LEN         (FLT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .ps2_clk_in  (clk_line),
        .ps2_data_in (data_line),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .tx_err      (tx_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_done) done_cnt++;
        if (tx_err) err_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       ack;
        int         exp_done;
        int         exp_err;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic start_tx(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    task automatic measure_rts();
        int n;
        n = 0;
        while (ps2_clk_oe && !ps2_data_oe && n < INH + 50) begin
            n++;
            @(negedge clk);
        end
        chk("inhibit_len", n, INH);
        n = 0;
        while (ps2_clk_oe && ps2_data_oe && n < RTSC + 50) begin
            n++;
            @(negedge clk);
        end
        chk("rts_len", n, RTSC);
        chk("start_bit_driven", ps2_data_oe, 1);
    endtask

    // Samples each bit while the clock is high, just before pulling it low.
    task automatic device(input logic ack_bit, input int poke_at, input int rst_at,
                          output logic [10:0] frame);
        frame = '0;
        repeat (HALF) @(negedge clk);
        for (int k = 1; k <= 11 && !rst; k++) begin
            frame[k-1] = data_line;
            if (k == 11) begin
                dev_data = ack_bit;
                repeat (2 * FLT + 2) @(negedge clk);
            end
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            if (k == rst_at) begin
                rst      = 1'b1;
                dev_clk  = 1'b1;
            end else begin
                if (k == poke_at) begin
                    tx_data  = 8'h3C;
                    tx_start = 1'b1;
                    @(negedge clk);
                    tx_start = 1'b0;
                end
                dev_clk = 1'b1;
                repeat (HALF) @(negedge clk);
            end
        end
        dev_data = 1'b1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (tx_busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("busy_release", tx_busy, 0);
    endtask

    task automatic run_vec(input logic [7:0] d, input logic par, input logic ack,
                           input int exp_done, input int exp_err, input int poke_at);
        logic [10:0] frame;
        int d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(d);
        measure_rts();
        device(ack, poke_at, 0, frame);
        wait_idle();
        chk("start_bit", frame[0], 0);
        chk("data_byte", frame[8:1], d);
        chk("parity_bit", frame[9], par);
        chk("stop_bit", frame[10], 1);
        chk("done_pulses", done_cnt - d0, exp_done);
        chk("err_pulses", err_cnt - e0, exp_err);
        chk("clk_released", ps2_clk_oe, 0);
        chk("data_released", ps2_data_oe, 0);
    endtask

    initial begin
        logic [10:0] frame;
        int n, d0, e0;
        vecs[0] = '{8'hED, 1'b1, 1'b0, 1, 0};
        vecs[1] = '{8'h00, 1'b1, 1'b0, 1, 0};
        vecs[2] = '{8'h01, 1'b0, 1'b0, 1, 0};
        vecs[3] = '{8'hA5, 1'b1, 1'b1, 0, 1};
        vecs[4] = '{8'hFF, 1'b1, 1'b0, 1, 0};

        repeat (5) @(negedge clk);
        chk("rst_clk_oe", ps2_clk_oe, 0);
        chk("rst_data_oe", ps2_data_oe, 0);
        chk("rst_busy", tx_busy, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_done", tx_done, 0);
        chk("idle_err", tx_err, 0);

        for (int i = 0; i < 5; i++)
            run_vec(vecs[i].data, vecs[i].par, vecs[i].ack, vecs[i].exp_done, vecs[i].exp_err, 0);

        // No device clocks: host must give up after the first-edge timeout.
        e0 = err_cnt;
        start_tx(8'h55);
        measure_rts();
        n = 0;
        while (!tx_err && n < 2 * FET) begin
            @(negedge clk);
            n++;
        end
        chk("first_edge_timeout_window", (n >= FET && n <= FET + 10), 1);
        chk("timeout_clk_oe", ps2_clk_oe, 0);
        chk("timeout_data_oe", ps2_data_oe, 0);
        wait_idle();
        chk("timeout_err_pulses", err_cnt - e0, 1);

        // A second tx_start mid-SEND must not disturb the byte on the wire.
        run_vec(8'hED, 1'b1, 1'b0, 1, 0, 3);
        repeat (100) @(negedge clk);
        chk("poke_no_restart_busy", tx_busy, 0);
        chk("poke_no_restart_clk", ps2_clk_oe, 0);

        // Reset after the fifth device fall, then a clean transfer.
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(8'h12);
        measure_rts();
        device(1'b0, 0, 5, frame);
        @(negedge clk);
        chk("midrst_clk_oe", ps2_clk_oe, 0);
        chk("midrst_data_oe", ps2_data_oe, 0);
        chk("midrst_busy", tx_busy, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        chk("midrst_no_done", done_cnt - d0, 0);
        chk("midrst_no_err", err_cnt - e0, 0);
        run_vec(8'hED, 1'b1, 1'b0, 1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
